// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding and sizing constants for bus_arbiter_n
package bus_pkg;

  localparam int N_MASTERS_MAX = 8;
  localparam int GRANT_W       = $clog2(N_MASTERS_MAX);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_ADDR_SEL = 3'd2,
    ST_CONNECT  = 3'd3,
    ST_ERROR    = 3'd4,
    ST_RELEASE  = 3'd5
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester after last_i, wrapping
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [GRANT_W-1:0]   last_i,
  output logic                 any_req_o,
  output logic [GRANT_W-1:0]   next_o
);

  logic               any_hi;
  logic [GRANT_W-1:0] next_hi;
  logic [GRANT_W-1:0] next_lo;

  // Downward scans leave the lowest match; the "hi" scan only sees indices above last_i.
  always_comb begin
    any_hi  = 1'b0;
    next_hi = '0;
    next_lo = '0;
    for (int j = N_MASTERS - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        next_lo = GRANT_W'(j);
        if (GRANT_W'(j) > last_i) begin
          any_hi  = 1'b1;
          next_hi = GRANT_W'(j);
        end
      end
    end
    any_req_o = |req_i;
    next_o    = any_hi ? next_hi : next_lo;
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// rtl/bus_arbiter_n.sv - N-master/N-slave serial bus arbiter with address decode and watchdog
module bus_arbiter_n
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3,
  parameter int SEL_W     = 2,
  parameter int TIMEOUT   = 1024,
  parameter int TO_W      = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] m_request,
  input  logic [N_MASTERS-1:0] m_address,
  input  logic [N_MASTERS-1:0] m_address_valid,
  input  logic [N_MASTERS-1:0] m_data,
  input  logic [N_MASTERS-1:0] m_valid,
  input  logic [N_MASTERS-1:0] m_write_en,
  input  logic [N_MASTERS-1:0] m_burst,
  output logic [N_MASTERS-1:0] m_available,
  output logic [N_MASTERS-1:0] m_ready,
  output logic [N_MASTERS-1:0] m_data_out,
  output logic [N_MASTERS-1:0] m_valid_out,
  output logic [N_MASTERS-1:0] m_error,
  output logic [N_SLAVES-1:0]  s_address,
  output logic [N_SLAVES-1:0]  s_data,
  output logic [N_SLAVES-1:0]  s_valid,
  output logic [N_SLAVES-1:0]  s_write_en,
  output logic [N_SLAVES-1:0]  s_burst,
  input  logic [N_SLAVES-1:0]  s_ready,
  input  logic [N_SLAVES-1:0]  s_data_in,
  input  logic [N_SLAVES-1:0]  s_valid_in,
  output logic [2:0]           state
);

  localparam int CNT_W = $clog2(SEL_W + 1);

  state_e             state_q;
  logic [GRANT_W-1:0] g_q;
  logic [GRANT_W-1:0] last_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic [TO_W-1:0]    to_q;

  logic [N_MASTERS-1:0] gnt_oh;
  logic [N_SLAVES-1:0]  sel_oh;
  logic                 any_req;
  logic [GRANT_W-1:0]   pick;

  rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
    .req_i     (m_request),
    .last_i    (last_q),
    .any_req_o (any_req),
    .next_o    (pick)
  );

  always_comb begin
    gnt_oh = '0;
    sel_oh = '0;
    for (int i = 0; i < N_MASTERS; i++) gnt_oh[i] = (g_q == GRANT_W'(i));
    for (int j = 0; j < N_SLAVES; j++) sel_oh[j] = (sel_q == SEL_W'(j));
  end

  logic req_g, addr_g, addr_v_g, data_g, valid_g, we_g, burst_g;
  logic rdy_s, din_s, vin_s;
  assign req_g    = |(m_request & gnt_oh);
  assign addr_g   = |(m_address & gnt_oh);
  assign addr_v_g = |(m_address_valid & gnt_oh);
  assign data_g   = |(m_data & gnt_oh);
  assign valid_g  = |(m_valid & gnt_oh);
  assign we_g     = |(m_write_en & gnt_oh);
  assign burst_g  = |(m_burst & gnt_oh);
  assign rdy_s    = |(s_ready & sel_oh);
  assign din_s    = |(s_data_in & sel_oh);
  assign vin_s    = |(s_valid_in & sel_oh);

  logic [SEL_W-1:0] sel_shift;
  logic             last_bit;
  logic             activity;
  assign sel_shift = SEL_W'({sel_q, addr_g});
  assign last_bit  = (bitcnt_q == CNT_W'(SEL_W - 1));
  assign activity  = addr_v_g | valid_g | vin_s;

  // A dropped request always wins over decode and timeout outcomes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      last_q   <= GRANT_W'(N_MASTERS - 1);
      sel_q    <= '0;
      bitcnt_q <= '0;
      to_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            g_q     <= pick;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: state_q <= req_g ? ST_ADDR_SEL : ST_RELEASE;
        ST_ADDR_SEL: begin
          if (!req_g) begin
            state_q <= ST_RELEASE;
          end else if (addr_v_g) begin
            sel_q    <= sel_shift;
            bitcnt_q <= bitcnt_q + CNT_W'(1);
            if (last_bit) state_q <= (int'(sel_shift) < N_SLAVES) ? ST_CONNECT : ST_ERROR;
          end
        end
        ST_CONNECT: begin
          if (!req_g) begin
            state_q <= ST_RELEASE;
          end else if (activity) begin
            to_q <= '0;
          end else begin
            to_q <= to_q + TO_W'(1);
            if (to_q == TO_W'(TIMEOUT - 1)) state_q <= ST_ERROR;
          end
        end
        ST_ERROR: if (!req_g) state_q <= ST_RELEASE;
        ST_RELEASE: begin
          last_q   <= g_q;
          bitcnt_q <= '0;
          to_q     <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic owned, connected;
  assign owned = (state_q == ST_GRANT) || (state_q == ST_ADDR_SEL) ||
                 (state_q == ST_CONNECT) || (state_q == ST_ERROR);
  assign connected = (state_q == ST_CONNECT);

  assign m_available = owned ? gnt_oh : '0;
  assign m_error     = (state_q == ST_ERROR) ? gnt_oh : '0;
  assign m_ready     = (connected && rdy_s) ? gnt_oh : '0;
  assign m_data_out  = (connected && din_s) ? gnt_oh : '0;
  assign m_valid_out = (connected && vin_s) ? gnt_oh : '0;
  assign s_address   = (connected && addr_g) ? sel_oh : '0;
  assign s_data      = (connected && data_g) ? sel_oh : '0;
  assign s_valid     = (connected && valid_g) ? sel_oh : '0;
  assign s_write_en  = (connected && we_g) ? sel_oh : '0;
  assign s_burst     = (connected && burst_g) ? sel_oh : '0;
  assign state       = state_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb/tb_bus_arbiter_n.sv - self-checking bench for bus_arbiter_n (3 masters, 3 slaves, TIMEOUT=8)
module tb_bus_arbiter_n;

  localparam int NM = 3;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NM-1:0] m_request, m_address, m_address_valid, m_data, m_valid, m_write_en, m_burst;
  logic [NM-1:0] m_available, m_ready, m_data_out, m_valid_out, m_error;
  logic [NS-1:0] s_address, s_data, s_valid, s_write_en, s_burst;
  logic [NS-1:0] s_ready, s_data_in, s_valid_in;
  logic [2:0]    state;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  logic [5*NM+5*NS-1:0] all_out;
  assign all_out = {m_available, m_ready, m_data_out, m_valid_out, m_error,
                    s_address, s_data, s_valid, s_write_en, s_burst};

  bus_arbiter_n #(.N_MASTERS(NM), .N_SLAVES(NS), .SEL_W(2), .TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .m_request(m_request), .m_address(m_address), .m_address_valid(m_address_valid),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en), .m_burst(m_burst),
    .m_available(m_available), .m_ready(m_ready), .m_data_out(m_data_out),
    .m_valid_out(m_valid_out), .m_error(m_error),
    .s_address(s_address), .s_data(s_data), .s_valid(s_valid),
    .s_write_en(s_write_en), .s_burst(s_burst),
    .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_in(s_valid_in),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_request = '0; m_address = '0; m_address_valid = '0; m_data = '0;
    m_valid = '0; m_write_en = '0; m_burst = '0;
    s_ready = '0; s_data_in = '0; s_valid_in = '0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state == st) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (state == st) ok = 1'b1;
  endtask

  task automatic connect(input logic [NM-1:0] mm, input logic [1:0] sb, output bit ok);
    bit w;
    m_request = m_request | mm;
    wait_state(3'd2, 20, w);
    m_address_valid = mm;
    m_address = sb[1] ? mm : '0;
    cyc();
    m_address = sb[0] ? mm : '0;
    cyc();
    m_address_valid = '0;
    m_address = '0;
    ok = w && (state == 3'd3);
  endtask

  task automatic test_reset();
    bit ok;
    clear_inputs();
    reset = 1'b1;
    cyc(); cyc(); settle();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", all_out); end
    reset = 1'b0;
    cyc();
    connect(3'b001, 2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_pre_connect got=%0d exp=3", state); end
    m_valid = 3'b001; m_data = 3'b001; settle();
    checks++; if (s_valid !== 3'b001) begin failures++; $display("FAIL reset_pre_route got=%b exp=001", s_valid); end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(); settle();
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_mid_state got=%0d exp=0", state); end
      checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_mid_outputs got=%0h exp=0", all_out); end
    end
    clear_inputs();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    int gap, e;
    bit found;
    logic [NM-1:0] exp_m;
    exp_q = {};
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    m_address_valid = '1;
    m_address = '0;
    m_request = '1;
    for (int n = 0; n < 4; n++) begin
      gap = 0;
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (state == 3'd1) begin found = 1'b1; break; end
        if (m_available == '0) gap++;
        cyc();
      end
      checks++; if (!found) begin failures++; $display("FAIL rr_grant_seen got=%0d exp=1", state); end
      e = exp_q.pop_front();
      exp_m = NM'(1) << e;
      settle();
      checks++; if (m_available !== exp_m) begin failures++; $display("FAIL rr_grant_%0d got=%b exp=%b", n, m_available, exp_m); end
      if (n > 0) begin
        checks++; if (gap !== 2) begin failures++; $display("FAIL rr_gap_%0d got=%0d exp=2", n, gap); end
      end
      for (int t = 0; t < 6; t++) cyc();
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL rr_connect_%0d got=%0d exp=3", n, state); end
      m_request = m_request & ~exp_m;
      cyc();
      m_request = (n == 3) ? '0 : '1;
    end
    clear_inputs();
    cyc(); cyc();
  endtask

  task automatic test_route();
    bit ok;
    int e;
    logic b;
    logic [7:0] pat;
    pat = 8'hA5;
    exp_q = {};
    m_write_en = 3'b010; m_burst = 3'b010;
    connect(3'b010, 2'b10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL route_connect got=%0d exp=3", state); end
    settle();
    checks++; if (s_write_en !== 3'b100 || s_burst !== 3'b100) begin
      failures++; $display("FAIL route_we_burst got=%b/%b exp=100/100", s_write_en, s_burst); end
    m_address_valid = 3'b111;
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom_range(0, 1));
      exp_q.push_back(int'(b));
      m_address = b ? 3'b010 : 3'b101;
      settle();
      e = exp_q.pop_front();
      checks++; if (s_address !== (e != 0 ? 3'b100 : 3'b000)) begin
        failures++; $display("FAIL route_addr_%0d got=%b exp_bit=%0d", i, s_address, e); end
      cyc();
    end
    m_address_valid = '0; m_address = '0;
    s_valid_in = 3'b111;
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(int'(pat[i]));
      s_data_in = pat[i] ? 3'b100 : 3'b011;
      settle();
      e = exp_q.pop_front();
      checks++; if (m_data_out !== (e != 0 ? 3'b010 : 3'b000)) begin
        failures++; $display("FAIL route_rdata_%0d got=%b exp_bit=%0d", i, m_data_out, e); end
      checks++; if (m_valid_out !== 3'b010) begin
        failures++; $display("FAIL route_rvalid_%0d got=%b exp=010", i, m_valid_out); end
      cyc();
    end
    clear_inputs();
    cyc(); settle();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL route_release got=%0d exp=5", state); end
    cyc(); settle();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL route_idle got=%0d exp=0", state); end
  endtask

  task automatic test_decode_error();
    bit ok;
    connect(3'b001, 2'b11, ok);
    m_valid = 3'b001; m_address_valid = 3'b001; m_data = 3'b001;
    settle();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL derr_state got=%0d exp=4", state); end
    checks++; if (m_error !== 3'b001) begin failures++; $display("FAIL derr_m_error got=%b exp=001", m_error); end
    checks++; if (s_valid !== '0 || s_address !== '0) begin failures++; $display("FAIL derr_no_slave got=%b exp=000", s_valid); end
    checks++; if (m_available !== 3'b001) begin failures++; $display("FAIL derr_avail got=%b exp=001", m_available); end
    cyc(); cyc(); cyc(); settle();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL derr_hold got=%0d exp=4", state); end
    m_request = '0;
    cyc(); settle();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL derr_release got=%0d exp=5", state); end
    checks++; if (all_out !== '0) begin failures++; $display("FAIL derr_release_out got=%0h exp=0", all_out); end
    cyc(); settle();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL derr_idle got=%0d exp=0", state); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_timeout();
    bit ok;
    connect(3'b100, 2'b01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_connect got=%0d exp=3", state); end
    for (int i = 0; i < 4; i++) cyc();
    settle();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL to_early got=%0d exp=3", state); end
    m_valid = 3'b100;
    cyc();
    m_valid = '0;
    for (int i = 0; i < 7; i++) cyc();
    settle();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL to_restart got=%0d exp=3", state); end
    cyc(); settle();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL to_expire got=%0d exp=4", state); end
    checks++; if (m_error !== 3'b100) begin failures++; $display("FAIL to_m_error got=%b exp=100", m_error); end
    clear_inputs();
    cyc(); cyc(); settle();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL to_idle got=%0d exp=0", state); end
  endtask

  task automatic test_mid_select_drop();
    bit ok, w;
    m_request = 3'b001;
    wait_state(3'd2, 20, w);
    checks++; if (!w) begin failures++; $display("FAIL drop_addr_sel got=%0d exp=2", state); end
    m_address_valid = 3'b001; m_address = 3'b001;
    cyc();
    m_address_valid = '0; m_address = '0; m_request = '0;
    cyc(); settle();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL drop_release got=%0d exp=5", state); end
    cyc(); settle();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL drop_idle got=%0d exp=0", state); end
    connect(3'b001, 2'b01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_reconnect got=%0d exp=3", state); end
    checks++; if (m_available !== 3'b001) begin failures++; $display("FAIL drop_regrant got=%b exp=001", m_available); end
    m_valid = 3'b001; m_data = 3'b001;
    settle();
    checks++; if (s_data !== 3'b010 || s_valid !== 3'b010) begin
      failures++; $display("FAIL drop_fresh_sel got=%b/%b exp=010/010", s_data, s_valid); end
    clear_inputs();
    cyc(); cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_route();
    test_decode_error();
    test_timeout();
    test_mid_select_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
